// File: rtl/pong_physics.sv
// pong_physics: frame-rate ball/paddle motion, wall and paddle bounces, miss detection.
// Optional macro SPEEDUP_EN: horizontal ball speed steps up on each paddle hit.
`timescale 1ns/1ps
module pong_physics #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned BORDER     = 10,
    parameter int unsigned BALL_SIZE  = 10,
    parameter int unsigned PAD_W      = 8,
    parameter int unsigned PAD_H      = 96,
    parameter int unsigned PAD_OFFSET = 20,
    parameter int unsigned BALL_SPEED = 2,
    parameter int unsigned PAD_SPEED  = 2,
    parameter int unsigned MAX_SPEED  = 6
) (
    input  logic       clk_pix,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic       serve_side,
    input  logic       launch,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] p1_y,
    output logic [9:0] p2_y,
    output logic [1:0] state,
    output logic       paddle_hit,
    output logic       miss_left,
    output logic       miss_right
);

    localparam int unsigned P1_EDGE  = BORDER + PAD_OFFSET + PAD_W;
    localparam int unsigned P2_EDGE  = H_RES - P1_EDGE;
    localparam int unsigned PAD_MAX  = V_RES - BORDER - PAD_H;
    localparam int unsigned Y_MAX    = V_RES - BORDER - BALL_SIZE;
    localparam int unsigned X_MISS   = H_RES - BORDER - BALL_SIZE;
    localparam int unsigned SERVE_DY = PAD_H / 2 - BALL_SIZE / 2;

    localparam logic [9:0] BALL_X0 = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0 = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_Y0  = 10'((V_RES - PAD_H) / 2);
    // Starting speed never exceeds the ceiling, so the saturating step stays monotonic.
    localparam logic [2:0] BASE_SPD = 3'((BALL_SPEED > MAX_SPEED) ? MAX_SPEED : BALL_SPEED);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        MISS  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [9:0] p1_q, p1_d, p2_q, p2_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic       hit_q, hit_d, miss_l_q, miss_l_d, miss_r_q, miss_r_d;
    logic [2:0] hspd;

`ifdef SPEEDUP_EN
    logic [2:0] spd_q, spd_d;
    assign hspd = spd_q;
`else
    assign hspd = BASE_SPD;
`endif

    function automatic logic [9:0] pad_next(input logic [9:0] p, input logic up, input logic dn);
        logic [9:0] r;
        r = p;
        if (up)
            r = (p <= 10'(BORDER + PAD_SPEED)) ? 10'(BORDER) : p - 10'(PAD_SPEED);
        else if (dn)
            r = (p + 10'(PAD_SPEED) >= 10'(PAD_MAX)) ? 10'(PAD_MAX) : p + 10'(PAD_SPEED);
        return r;
    endfunction

    logic       pads_live, serving;
    logic [9:0] p1_nx, p2_nx, serve_y;

    assign pads_live = (state_q == SERVE) || (state_q == PLAY);
    assign p1_nx     = pads_live ? pad_next(p1_q, p1_up, p1_down) : p1_q;
    assign p2_nx     = pads_live ? pad_next(p2_q, p2_up, p2_down) : p2_q;
    assign serve_y   = (serve_side ? p2_nx : p1_nx) + 10'(SERVE_DY);
    assign serving   = (state_q == SERVE) ||
                       (((state_q == IDLE) || (state_q == MISS)) && serve);

    // Horizontal geometry in 11 bits so edge sums never wrap.
    logic [10:0] bx, by, pa1, pa2, spd11, nx_l, nx_r;
    logic        ov1, ov2, hit_l, hit_r, out_l, out_r, hit_now, miss_now;

    assign bx    = {1'b0, ball_x_q};
    assign by    = {1'b0, ball_y_q};
    assign pa1   = {1'b0, p1_q};
    assign pa2   = {1'b0, p2_q};
    assign spd11 = {8'd0, hspd};
    assign nx_l  = bx - spd11;
    assign nx_r  = bx + spd11;

    assign ov1   = (by + 11'(BALL_SIZE) > pa1) && (by < pa1 + 11'(PAD_H));
    assign ov2   = (by + 11'(BALL_SIZE) > pa2) && (by < pa2 + 11'(PAD_H));
    assign hit_l = (nx_l <= 11'(P1_EDGE)) && (bx >= 11'(P1_EDGE)) && ov1;
    assign out_l = (nx_l <= 11'(BORDER));
    assign hit_r = (nx_r + 11'(BALL_SIZE) >= 11'(P2_EDGE)) &&
                   (bx + 11'(BALL_SIZE) <= 11'(P2_EDGE)) && ov2;
    assign out_r = (nx_r >= 11'(X_MISS));

    assign hit_now  = dx_q ? hit_l : hit_r;
    assign miss_now = dx_q ? (out_l && !hit_l) : (out_r && !hit_r);

    logic [9:0] ny;
    logic       ndy;

    always_comb begin
        ny  = ball_y_q;
        ndy = dy_q;
        if (!dy_q) begin
            if (ball_y_q + 10'(BALL_SPEED) >= 10'(Y_MAX)) begin
                ny  = 10'(Y_MAX);
                ndy = 1'b1;
            end else begin
                ny = ball_y_q + 10'(BALL_SPEED);
            end
        end else begin
            if (ball_y_q <= 10'(BORDER + BALL_SPEED)) begin
                ny  = 10'(BORDER);
                ndy = 1'b0;
            end else begin
                ny = ball_y_q - 10'(BALL_SPEED);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        hit_d    = 1'b0;
        miss_l_d = 1'b0;
        miss_r_d = 1'b0;
`ifdef SPEEDUP_EN
        spd_d    = spd_q;
`endif
        if (frame_tick) begin
            p1_d = p1_nx;
            p2_d = p2_nx;
            if (serving) begin
                ball_x_d = serve_side ? 10'(P2_EDGE - BALL_SIZE) : 10'(P1_EDGE);
                ball_y_d = serve_y;
                dx_d     = serve_side;
                dy_d     = 1'b0;
`ifdef SPEEDUP_EN
                spd_d    = BASE_SPD;
`endif
                state_d  = ((state_q == SERVE) && launch) ? PLAY : SERVE;
            end else if (state_q == PLAY) begin
                // A miss freezes the ball even when a wall bounce would coincide.
                if (miss_now) begin
                    state_d  = MISS;
                    miss_l_d = dx_q;
                    miss_r_d = !dx_q;
                end else begin
                    ball_y_d = ny;
                    dy_d     = ndy;
                    if (hit_now) begin
                        ball_x_d = dx_q ? 10'(P1_EDGE) : 10'(P2_EDGE - BALL_SIZE);
                        dx_d     = !dx_q;
                        hit_d    = 1'b1;
`ifdef SPEEDUP_EN
                        spd_d    = (spd_q >= 3'(MAX_SPEED)) ? 3'(MAX_SPEED) : spd_q + 3'd1;
`endif
                    end else begin
                        ball_x_d = dx_q ? nx_l[9:0] : nx_r[9:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_q  <= IDLE;
            ball_x_q <= BALL_X0;
            ball_y_q <= BALL_Y0;
            p1_q     <= PAD_Y0;
            p2_q     <= PAD_Y0;
            dx_q     <= 1'b0;
            dy_q     <= 1'b0;
            hit_q    <= 1'b0;
            miss_l_q <= 1'b0;
            miss_r_q <= 1'b0;
`ifdef SPEEDUP_EN
            spd_q    <= BASE_SPD;
`endif
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            hit_q    <= hit_d;
            miss_l_q <= miss_l_d;
            miss_r_q <= miss_r_d;
`ifdef SPEEDUP_EN
            spd_q    <= spd_d;
`endif
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign p1_y       = p1_q;
    assign p2_y       = p2_q;
    assign state      = state_q;
    assign paddle_hit = hit_q;
    assign miss_left  = miss_l_q;
    assign miss_right = miss_r_q;

endmodule

// File: tb/tb_pong_physics.sv
// Bench for pong_physics: random stimulus against a rule-level game model, plus fixed-value scenarios.
`timescale 1ns/1ps
module tb_pong_physics;

    logic       clk_pix = 1'b0;
    logic       reset, frame_tick, serve, serve_side, launch;
    logic       p1_up, p1_down, p2_up, p2_down;
    logic [9:0] ball_x, ball_y, p1_y, p2_y;
    logic [1:0] state;
    logic       paddle_hit, miss_left, miss_right;

    int total = 0;
    int bad   = 0;

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    // Game model: plain integers, updated from the game rules once per clock.
    int ms, mx, my, mp1, mp2, mdx, mdy, mspd, mhit, mml, mmr;

    logic [44:0] dut_v, mdl_v;
    assign dut_v = {state, ball_x, ball_y, p1_y, p2_y, paddle_hit, miss_left, miss_right};
    always_comb mdl_v = {ms[1:0], mx[9:0], my[9:0], mp1[9:0], mp2[9:0], mhit[0], mml[0], mmr[0]};

    pong_physics dut (
        .clk_pix    (clk_pix),
        .reset      (reset),
        .frame_tick (frame_tick),
        .serve      (serve),
        .serve_side (serve_side),
        .launch     (launch),
        .p1_up      (p1_up),
        .p1_down    (p1_down),
        .p2_up      (p2_up),
        .p2_down    (p2_down),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .p1_y       (p1_y),
        .p2_y       (p2_y),
        .state      (state),
        .paddle_hit (paddle_hit),
        .miss_left  (miss_left),
        .miss_right (miss_right)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic string fmt(input logic [44:0] v);
        return $sformatf("st=%0d x=%0d y=%0d p1=%0d p2=%0d hit=%0d ml=%0d mr=%0d",
                         v[44:43], v[42:33], v[32:23], v[22:13], v[12:3], v[2], v[1], v[0]);
    endfunction

    function automatic int pad_move(input int p, input logic up, input logic dn);
        if (up) return (p - 2 < 10) ? 10 : p - 2;
        if (dn) return (p + 2 > 374) ? 374 : p + 2;
        return p;
    endfunction

    task automatic place_serve(input int py1, input int py2);
        mx   = serve_side ? 592 : 38;
        my   = (serve_side ? py2 : py1) + 43;
        mdx  = serve_side;
        mdy  = 0;
        mspd = 2;
    endtask

    task automatic model_clk();
        int np1, np2, sp, nxp, ny, ndy;
        bit hit, miss;
        if (reset) begin
            ms = 0; mx = 315; my = 235; mp1 = 192; mp2 = 192;
            mdx = 0; mdy = 0; mspd = 2; mhit = 0; mml = 0; mmr = 0;
            return;
        end
        mhit = 0; mml = 0; mmr = 0;
        if (!frame_tick) return;
        np1 = pad_move(mp1, p1_up, p1_down);
        np2 = pad_move(mp2, p2_up, p2_down);
        sp  = SPEEDUP ? mspd : 2;
        case (ms)
            0, 3: if (serve) begin
                ms = 1;
                place_serve(mp1, mp2);
            end
            1: begin
                mp1 = np1; mp2 = np2;
                place_serve(mp1, mp2);
                if (launch) ms = 2;
            end
            default: begin
                hit = 0; miss = 0; nxp = mx;
                if (mdx == 1) begin
                    if (mx - sp <= 38 && mx >= 38 && my + 10 > mp1 && my < mp1 + 96) begin
                        nxp = 38; hit = 1;
                    end else if (mx - sp <= 10) begin
                        miss = 1; mml = 1;
                    end else nxp = mx - sp;
                end else begin
                    if (mx + 10 + sp >= 602 && mx + 10 <= 602 && my + 10 > mp2 && my < mp2 + 96) begin
                        nxp = 592; hit = 1;
                    end else if (mx + sp >= 620) begin
                        miss = 1; mmr = 1;
                    end else nxp = mx + sp;
                end
                ndy = mdy;
                if (mdy == 0) begin
                    if (my + 2 >= 460) begin ny = 460; ndy = 1; end
                    else ny = my + 2;
                end else begin
                    if (my <= 12) begin ny = 10; ndy = 0; end
                    else ny = my - 2;
                end
                if (miss) ms = 3;
                else begin
                    mx = nxp; my = ny; mdy = ndy;
                    if (hit) begin
                        mdx  = 1 - mdx;
                        mhit = 1;
                        mspd = (mspd + 1 > 6) ? 6 : mspd + 1;
                    end
                end
                mp1 = np1; mp2 = np2;
            end
        endcase
    endtask

    task automatic clk_cycle(input logic tk);
        frame_tick = tk;
        @(posedge clk_pix);
        model_clk();
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {serve, serve_side, launch, p1_up, p1_down, p2_up, p2_down} = '0;
        clk_cycle(1'b1);
        clk_cycle(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk_cycle(i[0] == 1'b0);
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL reset_idle: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
        end
        total++;
        if (dut_v !== {2'd0, 10'd315, 10'd235, 10'd192, 10'd192, 3'b000}) begin
            bad++;
            $display("FAIL reset_values: got %s want st=0 x=315 y=235 p1=192 p2=192 no pulses", fmt(dut_v));
        end
    endtask

    task automatic test_serve();
        serve = 1'b1; serve_side = 1'b0;
        clk_cycle(1'b1);
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 10'd38, 10'd235}) begin
            bad++;
            $display("FAIL serve_setup: got st=%0d (%0d,%0d) want st=1 (38,235)", state, ball_x, ball_y);
        end
        serve = 1'b0; p1_up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            clk_cycle(1'b1);
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL serve_track tick: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
            clk_cycle(1'b0);
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL serve_track idle: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
        end
        p1_up = 1'b0;
        total++;
        if ({p1_y, ball_x, ball_y} !== {10'd10, 10'd38, 10'd53}) begin
            bad++;
            $display("FAIL serve_saturate: got p1=%0d ball=(%0d,%0d) want p1=10 ball=(38,53)", p1_y, ball_x, ball_y);
        end
    endtask

    task automatic test_launch_and_reset();
        reset = 1'b1;
        clk_cycle(1'b0);
        reset = 1'b0;
        total++;
        if (dut_v !== {2'd0, 10'd315, 10'd235, 10'd192, 10'd192, 3'b000}) begin
            bad++;
            $display("FAIL reset_no_tick: got %s want st=0 x=315 y=235 p1=192 p2=192", fmt(dut_v));
        end
        serve = 1'b1; serve_side = 1'b0;
        clk_cycle(1'b1);
        serve = 1'b0; launch = 1'b1;
        clk_cycle(1'b1);
        launch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clk_cycle(1'b1);
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL launch_motion: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
        end
        total++;
        if ({state, ball_x, ball_y} !== {2'd2, 10'd78, 10'd275}) begin
            bad++;
            $display("FAIL launch_pos: got st=%0d (%0d,%0d) want st=2 (78,275)", state, ball_x, ball_y);
        end
        for (int i = 0; i < 30; i++) begin
            {p1_up, p1_down, p2_up, p2_down} = 4'($urandom);
            clk_cycle(1'($urandom_range(1)));
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL play_random: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
        end
        reset = 1'b1;
        clk_cycle(1'b0);
        reset = 1'b0;
        total++;
        if (dut_v !== {2'd0, 10'd315, 10'd235, 10'd192, 10'd192, 3'b000}) begin
            bad++;
            $display("FAIL reset_midplay: got %s want st=0 x=315 y=235 p1=192 p2=192", fmt(dut_v));
        end
    endtask

    task automatic test_miss_freeze();
        int fx, fy, fp1, fp2;
        serve = 1'b1; serve_side = 1'b0;
        clk_cycle(1'b1);
        serve = 1'b0; launch = 1'b1;
        clk_cycle(1'b1);
        launch = 1'b0;
        for (int c = 0; c < 3000 && ms != 3; c++) begin
            {p1_up, p1_down, p2_up, p2_down} = 4'($urandom);
            clk_cycle(1'b1);
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL miss_rally: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
        end
        total++;
        if (state !== 2'd3 || ms != 3) begin
            bad++;
            $display("FAIL miss_reached: got st=%0d model st=%0d want 3 within budget", state, ms);
        end
        fx = mx; fy = my; fp1 = mp1; fp2 = mp2;
        for (int i = 0; i < 10; i++) begin
            {p1_up, p1_down, p2_up, p2_down} = 4'($urandom);
            launch = 1'($urandom_range(1));
            clk_cycle(1'b1);
            total++;
            if (dut_v !== mdl_v) begin
                bad++;
                $display("FAIL miss_hold: got %s want %s", fmt(dut_v), fmt(mdl_v));
            end
        end
        launch = 1'b0;
        total++;
        if ({state, ball_x, ball_y, p1_y, p2_y} !== {2'd3, 10'(fx), 10'(fy), 10'(fp1), 10'(fp2)}) begin
            bad++;
            $display("FAIL miss_frozen: got st=%0d (%0d,%0d) p1=%0d p2=%0d want st=3 (%0d,%0d) p1=%0d p2=%0d",
                     state, ball_x, ball_y, p1_y, p2_y, fx, fy, fp1, fp2);
        end
        serve = 1'b1; serve_side = 1'b1;
        {p1_up, p1_down, p2_up, p2_down} = '0;
        clk_cycle(1'b1);
        serve = 1'b0;
        total++;
        if ({state, ball_x, ball_y} !== {2'd1, 10'd592, 10'(fp2 + 43)}) begin
            bad++;
            $display("FAIL reserve_p2: got st=%0d (%0d,%0d) want st=1 (592,%0d)", state, ball_x, ball_y, fp2 + 43);
        end
    endtask

    task automatic test_random_play();
        for (int r = 0; r < 6; r++) begin
            int noise;
            noise = 10 + r * 15;
            serve = 1'b1; serve_side = 1'($urandom_range(1)); launch = 1'b0;
            for (int c = 0; c < 30; c++) begin
                {p1_up, p1_down, p2_up, p2_down} = 4'($urandom);
                if (c == 3) serve = 1'b0;
                if (c == 20) launch = 1'b1;
                clk_cycle((c < 4 || c >= 20) ? 1'b1 : 1'($urandom_range(1)));
                total++;
                if (dut_v !== mdl_v) begin
                    bad++;
                    $display("FAIL rally_serve r=%0d: got %s want %s", r, fmt(dut_v), fmt(mdl_v));
                end
            end
            launch = 1'b0;
            for (int c = 0; c < 4000 && ms != 3; c++) begin
                if ($urandom_range(99) < noise) {p1_up, p1_down} = 2'($urandom);
                else begin
                    p1_up   = (mp1 + 48 > my + 7);
                    p1_down = (mp1 + 48 < my + 3);
                end
                if ($urandom_range(99) < noise) {p2_up, p2_down} = 2'($urandom);
                else begin
                    p2_up   = (mp2 + 48 > my + 7);
                    p2_down = (mp2 + 48 < my + 3);
                end
                serve  = ($urandom_range(15) == 0);
                launch = ($urandom_range(15) == 0);
                clk_cycle($urandom_range(3) != 0);
                total++;
                if (dut_v !== mdl_v) begin
                    bad++;
                    $display("FAIL rally_play r=%0d: got %s want %s", r, fmt(dut_v), fmt(mdl_v));
                end
            end
            serve = 1'b0; launch = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0;
        {serve, serve_side, launch, p1_up, p1_down, p2_up, p2_down} = '0;
        test_reset();
        test_serve();
        test_launch_and_reset();
        test_miss_freeze();
        test_random_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
